// File: rtl/idelay_load_sequencer.sv
// Shared delay-bus sequencer: queues per-lane delay writes, strobes each lane's load pipe, then a common apply.
// Optional IDELAY_FINE_CLAMP_EN clamps an out-of-range fine field to 4 on the bus.
module idelay_load_sequencer #(
  parameter int NUM_LANES = 9,
  parameter int LANE_BITS = 4,
  parameter int FIFO_LOG2 = 2,
  parameter int SET_GAP   = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [LANE_BITS-1:0] cmd_lane,
  input  logic [7:0]           cmd_delay,
  input  logic                 cmd_apply,
  output logic [7:0]           dly_out,
  output logic [NUM_LANES-1:0] ld_out,
  output logic                 set_out,
  output logic                 busy,
  output logic                 done,
  output logic                 err_lane,
  output logic                 err_fine,
  input  logic                 err_clr
);

  localparam int DEPTH = 1 << FIFO_LOG2;
  localparam int EW    = 1 + LANE_BITS + 8;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_GAP  = 2'd2;
  localparam logic [1:0] S_SET  = 2'd3;

  localparam logic [3:0]         GAP_LAST   = (SET_GAP == 0) ? 4'd0 : 4'(SET_GAP - 1);
  localparam logic [LANE_BITS:0] LANE_LIMIT = (LANE_BITS + 1)'(NUM_LANES);

  logic [EW-1:0]          r_mem [DEPTH];
  logic [FIFO_LOG2-1:0]   r_wr_ptr, r_rd_ptr;
  logic [FIFO_LOG2:0]     r_count;
  logic                   r_ready;
  logic [1:0]             r_state;
  logic [3:0]             r_gap_cnt;
  logic                   r_apply;
  logic [7:0]             r_dly;
  logic [NUM_LANES-1:0]   r_ld;
  logic                   r_set, r_done, r_err_lane, r_err_fine;

  logic                   w_push, w_pop, w_empty;
  logic [EW-1:0]          w_head;
  logic [LANE_BITS-1:0]   w_head_lane;
  logic [7:0]             w_head_dly, w_load_dly;
  logic                   w_lane_bad, w_fine_bad;
  logic [NUM_LANES-1:0]   w_onehot;
  logic [FIFO_LOG2:0]     w_count_next;

  assign w_empty     = (r_count == '0);
  assign w_push      = cmd_valid & r_ready;
  // Popping is only allowed when the next cycle can be a LOAD; GAP/SET hold the queue.
  assign w_pop       = !w_empty && ((r_state == S_IDLE) || ((r_state == S_LOAD) && !r_apply));
  assign w_head      = r_mem[r_rd_ptr];
  assign w_head_lane = w_head[8 +: LANE_BITS];
  assign w_head_dly  = w_head[7:0];
  assign w_lane_bad  = ({1'b0, w_head_lane} >= LANE_LIMIT);
  assign w_fine_bad  = (w_head_dly[2:0] > 3'd4);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_LANES; gi++) begin : g_onehot
      assign w_onehot[gi] = (w_head_lane == LANE_BITS'(gi));
    end
  endgenerate

`ifdef IDELAY_FINE_CLAMP_EN
  assign w_load_dly = {w_head_dly[7:3], (w_fine_bad ? 3'd4 : w_head_dly[2:0])};
`else
  assign w_load_dly = w_head_dly;
`endif

  assign w_count_next = r_count + (FIFO_LOG2 + 1)'(w_push) - (FIFO_LOG2 + 1)'(w_pop);

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= {cmd_apply, cmd_lane, cmd_delay};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_ready    <= 1'b1;
      r_state    <= S_IDLE;
      r_gap_cnt  <= '0;
      r_apply    <= 1'b0;
      r_dly      <= '0;
      r_ld       <= '0;
      r_set      <= 1'b0;
      r_done     <= 1'b0;
      r_err_lane <= 1'b0;
      r_err_fine <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + FIFO_LOG2'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + FIFO_LOG2'(1);
      r_count <= w_count_next;
      r_ready <= (w_count_next != (FIFO_LOG2 + 1)'(DEPTH));

      r_set  <= 1'b0;
      r_done <= r_set;
      case (r_state)
        S_IDLE: if (w_pop) r_state <= S_LOAD;
        S_LOAD: begin
          if (r_apply) begin
            r_ld      <= '0;
            r_gap_cnt <= '0;
            if (SET_GAP == 0) begin
              r_state <= S_SET;
              r_set   <= 1'b1;
            end else begin
              r_state <= S_GAP;
            end
          end else if (!w_pop) begin
            r_ld    <= '0;
            r_state <= S_IDLE;
          end
        end
        S_GAP: begin
          if (r_gap_cnt == GAP_LAST) begin
            r_state <= S_SET;
            r_set   <= 1'b1;
          end else begin
            r_gap_cnt <= r_gap_cnt + 4'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase

      if (w_pop) begin
        r_ld    <= w_onehot;
        r_dly   <= w_load_dly;
        r_apply <= w_head[EW-1];
      end

      // A new error event takes priority over a simultaneous clear.
      if (w_pop && w_lane_bad) r_err_lane <= 1'b1;
      else if (err_clr)        r_err_lane <= 1'b0;
      if (w_pop && w_fine_bad) r_err_fine <= 1'b1;
      else if (err_clr)        r_err_fine <= 1'b0;
    end
  end

  assign cmd_ready = r_ready;
  assign dly_out   = r_dly;
  assign ld_out    = r_ld;
  assign set_out   = r_set;
  assign done      = r_done;
  assign err_lane  = r_err_lane;
  assign err_fine  = r_err_fine;
  assign busy      = (r_state != S_IDLE) || !w_empty;

endmodule

// File: tb/tb_idelay_load_sequencer.sv
// Scoreboard bench for idelay_load_sequencer: stimulus pushes expected strobes, a monitor checks them.
module tb_idelay_load_sequencer;
  localparam int NL = 9;
  localparam int LB = 4;
  localparam int FL = 2;
  localparam int SG = 2;

  logic          clk = 0;
  logic          rst = 1;
  logic          cmd_valid = 0;
  logic          cmd_ready;
  logic [LB-1:0] cmd_lane = '0;
  logic [7:0]    cmd_delay = '0;
  logic          cmd_apply = 0;
  logic [7:0]    dly_out;
  logic [NL-1:0] ld_out;
  logic          set_out, busy, done, err_lane, err_fine;
  logic          err_clr = 0;

  idelay_load_sequencer #(.NUM_LANES(NL), .LANE_BITS(LB), .FIFO_LOG2(FL), .SET_GAP(SG)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_lane(cmd_lane),
    .cmd_delay(cmd_delay), .cmd_apply(cmd_apply), .dly_out(dly_out), .ld_out(ld_out),
    .set_out(set_out), .busy(busy), .done(done), .err_lane(err_lane), .err_fine(err_fine),
    .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit            is_set;
    logic [NL-1:0] ld;
    logic [7:0]    dly;
    bit            chk_lat;
    bit            chk_consec;
    bit            chk_gap;
    int            push_cyc;
  } ev_t;

  ev_t  exp_q[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   last_ld_cyc = -100;
  bit   prev_set = 0;
  bit   saw_not_ready = 0;
  bit   m_err_lane = 0, m_err_fine = 0;
  logic [7:0] m_last_dly = 8'h00;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [7:0] exp_dly(input logic [7:0] d);
`ifdef IDELAY_FINE_CLAMP_EN
    if (d[2:0] > 3'd4) return {d[7:3], 3'd4};
`endif
    return d;
  endfunction

  // Monitor: every strobe the DUT shows must match the oldest expected event.
  always @(negedge clk) begin
    if (rst) begin
      prev_set = 0;
    end else begin
      chk("done_after_set", {31'd0, done}, {31'd0, prev_set});
      prev_set = set_out;
      if (ld_out != '0 || set_out) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_strobe", {22'd0, set_out, ld_out}, 32'd0);
        end else begin
          ev_t ev;
          ev = exp_q.pop_front();
          if (!ev.is_set) begin
            chk("ld_onehot", {23'd0, ld_out}, {23'd0, ev.ld});
            chk("ld_dly", {24'd0, dly_out}, {24'd0, ev.dly});
            if (ev.chk_lat) chk("ld_latency", cyc - ev.push_cyc, 2);
            if (ev.chk_consec) chk("ld_consecutive", cyc - last_ld_cyc, 1);
            last_ld_cyc = cyc;
            $display("[TB] cycle %0d ld_out=0x%03h dly_out=0x%02h", cyc, ld_out, dly_out);
          end else begin
            chk("set_pulse", {31'd0, set_out}, 32'd1);
            chk("set_no_ld", {23'd0, ld_out}, 32'd0);
            if (ev.chk_gap) chk("set_gap", cyc - last_ld_cyc, SG + 1);
            $display("[TB] cycle %0d set_out", cyc);
          end
        end
      end
    end
  end

  task automatic push_cmd(input int lane, input logic [7:0] d, input bit apply,
                          input bit lat, input bit consec);
    bit rdy, ok;
    int pc;
    ev_t ev;
    ok = 0;
    cmd_valid = 1;
    cmd_lane  = LB'(lane);
    cmd_delay = d;
    cmd_apply = apply;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      rdy = cmd_ready;
      pc  = cyc;
      if (!rdy) saw_not_ready = 1;
      @(posedge clk);
      #1;
      if (rdy) begin ok = 1; break; end
    end
    if (!ok) begin
      chk("push_timeout", 32'd1, 32'd0);
    end else begin
      m_last_dly = exp_dly(d);
      if (d[2:0] > 3'd4) m_err_fine = 1;
      if (lane >= NL) begin
        m_err_lane = 1;
      end else begin
        ev.is_set = 0; ev.ld = '0; ev.ld[lane] = 1'b1; ev.dly = exp_dly(d);
        ev.chk_lat = lat; ev.chk_consec = consec; ev.chk_gap = 0; ev.push_cyc = pc;
        exp_q.push_back(ev);
      end
      if (apply) begin
        ev.is_set = 1; ev.ld = '0; ev.dly = 8'h00; ev.chk_lat = 0; ev.chk_consec = 0;
        ev.chk_gap = (lane < NL); ev.push_cyc = pc;
        exp_q.push_back(ev);
      end
      $display("[TB] push lane=%0d delay=0x%02h apply=%0d", lane, d, apply);
    end
  endtask

  task automatic idle(input int n);
    cmd_valid = 0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain_and_check(input string tag);
    bit ok;
    ok = 0;
    cmd_valid = 0;
    for (int t = 0; t < 300; t++) begin
      @(negedge clk);
      if (!busy && !done && exp_q.size() == 0) begin ok = 1; break; end
    end
    @(negedge clk);
    chk({tag, "_drained"}, {31'd0, ok}, 32'd1);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_dly_hold"}, {24'd0, dly_out}, {24'd0, m_last_dly});
    chk({tag, "_err_lane"}, {31'd0, err_lane}, {31'd0, m_err_lane});
    chk({tag, "_err_fine"}, {31'd0, err_fine}, {31'd0, m_err_fine});
    @(posedge clk);
    #1;
  endtask

  task automatic clear_errors();
    err_clr = 1;
    @(posedge clk);
    #1;
    err_clr = 0;
    m_err_lane = 0;
    m_err_fine = 0;
    @(negedge clk);
    chk("clr_err_lane", {31'd0, err_lane}, 32'd0);
    chk("clr_err_fine", {31'd0, err_fine}, 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_dly"}, {24'd0, dly_out}, 32'd0);
    chk({tag, "_ld"}, {23'd0, ld_out}, 32'd0);
    chk({tag, "_set"}, {31'd0, set_out}, 32'd0);
    chk({tag, "_done"}, {31'd0, done}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_errs"}, {30'd0, err_lane, err_fine}, 32'd0);
    chk({tag, "_ready"}, {31'd0, cmd_ready}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_reset_values("reset");
    rst = 0;
    idle(2);

    // Single apply entry on lane 3.
    push_cmd(3, 8'h2C, 1, 1, 0);
    drain_and_check("single");

    // Lanes 0..8 back to back, apply only on the last.
    for (int l = 0; l < NL; l++)
      push_cmd(l, 8'(l * 8), (l == NL - 1), (l == 0), (l != 0));
    drain_and_check("batch");

    // Six held commands against a four-deep queue; the apply stalls popping.
    saw_not_ready = 0;
    push_cmd(0, 8'h11, 1, 0, 0);
    for (int k = 1; k < 6; k++) push_cmd(k, 8'(8'h20 + k), 0, 0, 0);
    chk("full_ready_low", {31'd0, saw_not_ready}, 32'd1);
    drain_and_check("full");

    // Out-of-range lane still produces the apply strobe.
    push_cmd(12, 8'h30, 1, 0, 0);
    drain_and_check("badlane");
    clear_errors();

    // Fine field beyond 4.
    push_cmd(2, 8'h07, 0, 0, 0);
    drain_and_check("fine");
    clear_errors();

    // Randomized traffic.
    for (int n = 0; n < 40; n++) begin
      int lane, gap;
      lane = ($urandom_range(0, 7) == 0) ? (NL + int'($urandom_range(0, 15 - NL))) : int'($urandom_range(0, NL - 1));
      push_cmd(lane, 8'($urandom_range(0, 255)), ($urandom_range(0, 3) == 0), 0, 0);
      gap = $urandom_range(0, 3);
      if (gap != 0) idle(gap);
    end
    drain_and_check("random");
    clear_errors();

    // Reset while in GAP with further entries queued.
    push_cmd(1, 8'h10, 1, 0, 0);
    push_cmd(4, 8'h18, 0, 0, 0);
    push_cmd(5, 8'h28, 0, 0, 0);
    cmd_valid = 0;
    #2;
    rst = 1;
    exp_q.delete();
    m_err_lane = 0;
    m_err_fine = 0;
    m_last_dly = 8'h00;
    #1;
    check_reset_values("midrst");
    repeat (2) @(posedge clk);
    #1;
    rst = 0;
    repeat (15) @(posedge clk);
    #1;
    chk("post_rst_ready", {31'd0, cmd_ready}, 32'd1);
    chk("post_rst_busy", {31'd0, busy}, 32'd0);
    chk("post_rst_dly", {24'd0, dly_out}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
